hilo_muldiv_unit: RTL

//  Iterative multiply/divide sequencer with HI/LO registers for the single-cycle MIPS core.

---
 rtl/hilo_muldiv_unit_if.sv | 27 ++
 rtl/hilo_muldiv_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between the execute stage and the HI/LO multiply/divide unit.
`timescale 1ns/1ps
interface hilo_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] Ainput;
    logic [WIDTH-1:0] Binput;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op, Ainput, Binput, hi_we, lo_we, wdata,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, op, Ainput, Binput, hi_we, lo_we, wdata,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative mult/multu/div/divu sequencer owning the HI/LO registers; also services mthi/mtlo.
// One operand bit per cycle in MUL/DIV, sign fix-up and HI/LO write in FIX.
`timescale 1ns/1ps
module hilo_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    hilo_muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_is_div, r_dz, r_sq, r_sr;
    logic               r_busy, r_done;
    logic [WIDTH-1:0]   r_hi, r_lo;

    logic               w_load, w_busy_nxt, w_done_nxt, w_signed, w_bzero;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_acc_lo_init;
    logic [WIDTH:0]     w_mul_sum, w_div_top, w_div_diff;
    logic [2*WIDTH-1:0] w_mul_step, w_div_step, w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem, w_fix_hi, w_fix_lo;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? WIDTH'(-v) : v;
    endfunction

    assign w_signed      = ~bus.op[0];
    assign w_bzero       = (bus.Binput == '0);
    assign w_a_mag       = mag(bus.Ainput, w_signed);
    assign w_b_mag       = mag(bus.Binput, w_signed);
    // Divide-by-zero parks the raw dividend in the accumulator so FIX can return it as HI.
    assign w_acc_lo_init = !bus.op[1] ? w_b_mag : (w_bzero ? bus.Ainput : w_a_mag);

    // Shift-add: add multiplicand into the upper half when the current multiplier bit is set.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: {remainder, quotient} shifts left; a borrow keeps the old remainder.
    assign w_div_top  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff = w_div_top - {1'b0, r_b};
    assign w_div_step = w_div_diff[WIDTH] ? {w_div_top[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b0}
                                          : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prod = r_sq ? (2*WIDTH)'(-r_acc) : r_acc;
    assign w_quo  = r_sq ? WIDTH'(-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    assign w_rem  = r_sr ? WIDTH'(-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_dz) begin
            w_fix_hi = r_acc[WIDTH-1:0];
            w_fix_lo = '1;
        end else if (r_is_div) begin
            w_fix_hi = w_rem;
            w_fix_lo = w_quo;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        unique case (r_state)
            S_IDLE: if (bus.start) begin
                w_load = 1'b1;
                if (!bus.op[1])   w_state_nxt = S_MUL;
                else if (w_bzero) w_state_nxt = S_FIX;
                else              w_state_nxt = S_DIV;
            end
            S_MUL:  if (r_cnt == CNT_W'(WIDTH-1)) w_state_nxt = S_FIX;
            S_DIV:  if (r_cnt == CNT_W'(WIDTH-1)) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (r_state == S_FIX);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_sq     <= 1'b0;
            r_sr     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            unique case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_cnt    <= '0;
                        r_is_div <= bus.op[1];
                        r_dz     <= bus.op[1] & w_bzero;
                        r_sq     <= w_signed & (bus.Ainput[WIDTH-1] ^ bus.Binput[WIDTH-1]);
                        r_sr     <= w_signed & bus.Ainput[WIDTH-1];
                        r_b      <= bus.op[1] ? w_b_mag : w_a_mag;
                        r_acc    <= {WIDTH'(0), w_acc_lo_init};
                    end else begin
                        if (bus.hi_we) r_hi <= bus.wdata;
                        if (bus.lo_we) r_lo <= bus.wdata;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_step;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_DIV: begin
                    r_acc <= w_div_step;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;
endmodule
